reg_file_io: RTL and testbench

- Parametrised successor to the single-port, single-I/O register file used by the one-cycle CPU datapath.
- Provides NUM_GPR general registers, NUM_IO bidirectional I/O ports, and a per-bit direction register for each port.
- Has two combinational read ports (ALU operands A/B) and one synchronous write port.
- Pad inputs pass through a synchroniser, and the block raises a per-port change-detect pulse.

---
 rtl/reg_file_io.sv | 115 +++++++++++
 tb/tb_reg_file_io.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_io.sv
// reg_file_io: register file for the one-cycle CPU datapath.
//   NUM_GPR general registers, NUM_IO bidirectional I/O ports, each with an
//   output latch (OUT_k) and a per-bit direction register (DIR_k, 1 = drive).
//   Two combinational read ports, one synchronous write port, synchronised
//   pad inputs and a registered per-port input change-detect pulse.
//
// Address map: 0..NUM_GPR-1 GPRs, NUM_GPR+k OUT_k, NUM_GPR+NUM_IO+k DIR_k,
// anything above reads 0 and ignores writes.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   we/waddr/wdata         write port
//   raddr_a/rdata_a        read port A (combinational)
//   raddr_b/rdata_b        read port B (combinational)
//   io          pad bus, port k at [k*WIDTH +: WIDTH]
//   io_changed  one-cycle pulse per port when an input-direction bit changes
module reg_file_io #(
  parameter int WIDTH       = 8,
  parameter int NUM_GPR     = 8,
  parameter int NUM_IO      = 2,
  parameter int SYNC_STAGES = 2,
  localparam int AW         = $clog2(NUM_GPR + 2 * NUM_IO)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [AW-1:0]           raddr_a,
  output logic [WIDTH-1:0]        rdata_a,
  input  logic [AW-1:0]           raddr_b,
  output logic [WIDTH-1:0]        rdata_b,
  inout  wire  [NUM_IO*WIDTH-1:0] io,
  output logic [NUM_IO-1:0]       io_changed
);

  logic [WIDTH-1:0] gpr     [NUM_GPR];
  logic [WIDTH-1:0] out_q   [NUM_IO];
  logic [WIDTH-1:0] dir_q   [NUM_IO];
  logic [WIDTH-1:0] sync_q  [NUM_IO][SYNC_STAGES];
  logic [WIDTH-1:0] prev_q  [NUM_IO];
  logic [WIDTH-1:0] syn     [NUM_IO];
  logic [WIDTH-1:0] port_rd [NUM_IO];

  // Register writes; unmapped addresses match nothing and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
      for (int unsigned k = 0; k < NUM_IO; k++) begin
        out_q[k] <= '0;
        dir_q[k] <= '0;
      end
    end else if (we) begin
      for (int unsigned i = 0; i < NUM_GPR; i++)
        if (waddr == AW'(i)) gpr[i] <= wdata;
      for (int unsigned k = 0; k < NUM_IO; k++) begin
        if (waddr == AW'(NUM_GPR + k)) out_q[k] <= wdata;
        if (waddr == AW'(NUM_GPR + NUM_IO + k)) dir_q[k] <= wdata;
      end
    end
  end

  // Pad synchroniser and change detect. The chain samples the pad as seen,
  // so output-driven bits also flow through; they are masked by DIR only at
  // the change-detect and readback stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_IO; k++) begin
        for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[k][s] <= '0;
        prev_q[k] <= '0;
      end
      io_changed <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_IO; k++) begin
        sync_q[k][0] <= io[k*WIDTH +: WIDTH];
        for (int unsigned s = 1; s < SYNC_STAGES; s++)
          sync_q[k][s] <= sync_q[k][s-1];
        prev_q[k]     <= syn[k];
        io_changed[k] <= |((syn[k] ^ prev_q[k]) & ~dir_q[k]);
      end
    end
  end

  // Port readback: output bits show the latch, input bits the synchronised pad.
  always_comb begin
    for (int unsigned k = 0; k < NUM_IO; k++) begin
      syn[k]     = sync_q[k][SYNC_STAGES-1];
      port_rd[k] = (dir_q[k] & out_q[k]) | (~dir_q[k] & syn[k]);
    end
  end

  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int unsigned i = 0; i < NUM_GPR; i++) begin
      if (raddr_a == AW'(i)) rdata_a = gpr[i];
      if (raddr_b == AW'(i)) rdata_b = gpr[i];
    end
    for (int unsigned k = 0; k < NUM_IO; k++) begin
      if (raddr_a == AW'(NUM_GPR + k))          rdata_a = port_rd[k];
      if (raddr_b == AW'(NUM_GPR + k))          rdata_b = port_rd[k];
      if (raddr_a == AW'(NUM_GPR + NUM_IO + k)) rdata_a = dir_q[k];
      if (raddr_b == AW'(NUM_GPR + NUM_IO + k)) rdata_b = dir_q[k];
    end
  end

  // Per-bit tristate pad drivers.
  for (genvar k = 0; k < NUM_IO; k++) begin : g_port
    for (genvar j = 0; j < WIDTH; j++) begin : g_bit
      assign io[k*WIDTH + j] = dir_q[k][j] ? out_q[k][j] : 1'bz;
    end
  end

endmodule

// File: tb/tb_reg_file_io.sv
// tb_reg_file_io: directed bench for reg_file_io. Instance u0 uses default
// parameters and is tracked every cycle by a behavioural model; instance u1
// (WIDTH=16, NUM_GPR=16, NUM_IO=3, SYNC_STAGES=3) gets directed checks.
module tb_reg_file_io;

  localparam int S0 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // u0 signals
  logic       rst_n, we;
  logic [3:0] waddr, raddr_a, raddr_b;
  logic [7:0] wdata, rdata_a, rdata_b;
  wire  [15:0] io;
  logic [1:0] io_changed;
  logic [1:0][7:0] tb_val;

  // u1 signals
  logic        we1;
  logic [4:0]  waddr1, ra1a, ra1b;
  logic [15:0] wdata1, rd1a, rd1b;
  wire  [47:0] io1;
  logic [2:0]  ch1;
  logic [47:0] en1, val1;

  reg_file_io #(.WIDTH(8), .NUM_GPR(8), .NUM_IO(2), .SYNC_STAGES(S0)) u0 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
    .io(io), .io_changed(io_changed)
  );

  reg_file_io #(.WIDTH(16), .NUM_GPR(16), .NUM_IO(3), .SYNC_STAGES(3)) u1 (
    .clk(clk), .rst_n(rst_n), .we(we1), .waddr(waddr1), .wdata(wdata1),
    .raddr_a(ra1a), .rdata_a(rd1a), .raddr_b(ra1b), .rdata_b(rd1b),
    .io(io1), .io_changed(ch1)
  );

  // ---------------- behavioural model of u0 ----------------
  logic [7:0]      m_gpr [8];
  logic [1:0][7:0] m_out, m_dir, m_prev;
  logic [1:0]      m_chg;
  logic [15:0]     pad_log [64];   // pad value sampled at edge n
  int              cyc  = 0;       // edges taken out of reset so far
  int              base = 0;       // edge index of the last reset

  // The bench drives every bit the model says is an input.
  for (genvar i = 0; i < 16; i++) begin : g_drv0
    assign io[i] = m_dir[i/8][i%8] ? 1'bz : tb_val[i/8][i%8];
  end
  for (genvar i = 0; i < 48; i++) begin : g_drv1
    assign io1[i] = en1[i] ? val1[i] : 1'bz;
  end

  function automatic logic [7:0] m_pad(input int k);
    return (m_dir[k] & m_out[k]) | (~m_dir[k] & tb_val[k]);
  endfunction

  // Synchronised value: what the pad held S0 edges ago (0 if reset since).
  function automatic logic [7:0] m_syn(input int k);
    logic [15:0] v;
    if (cyc - S0 < base) return 8'h00;
    v = pad_log[(cyc - S0) % 64];
    return v[k*8 +: 8];
  endfunction

  function automatic logic [7:0] m_read(input logic [3:0] addr);
    int a;
    a = int'(addr);
    if (a < 8)  return m_gpr[a];
    if (a < 10) return (m_dir[a-8] & m_out[a-8]) | (~m_dir[a-8] & m_syn(a-8));
    if (a < 12) return m_dir[a-10];
    return 8'h00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] s;
    int a;
    if (!rst_n) begin
      foreach (m_gpr[i]) m_gpr[i] <= '0;
      m_out  <= '0;
      m_dir  <= '0;
      m_prev <= '0;
      m_chg  <= '0;
      base = cyc;
    end else begin
      for (int k = 0; k < 2; k++) begin
        s = m_syn(k);
        m_chg[k]  <= |((s ^ m_prev[k]) & ~m_dir[k]);
        m_prev[k] <= s;
      end
      pad_log[cyc % 64] = {m_pad(1), m_pad(0)};
      cyc++;
      if (we) begin
        a = int'(waddr);
        if (a < 8)       m_gpr[a]      <= wdata;
        else if (a < 10) m_out[a-8]    <= wdata;
        else if (a < 12) m_dir[a-10]   <= wdata;
      end
    end
  end

  // ---------------- checking ----------------
  int   n_vec  = 0;
  int   n_err  = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("cyc_rdata_a",    32'(rdata_a),    32'(m_read(raddr_a)));
      chk("cyc_rdata_b",    32'(rdata_b),    32'(m_read(raddr_b)));
      chk("cyc_io_changed", 32'(io_changed), 32'(m_chg));
      chk("cyc_pad",        32'(io),         32'({m_pad(1), m_pad(0)}));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick(1);
    we = 1'b0;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [15:0] d);
    we1 = 1'b1; waddr1 = a; wdata1 = d;
    tick(1);
    we1 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    tb_val = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0; ra1a = '0; ra1b = '0;
    en1 = '1; val1 = '0;
    #22 rst_n = 1'b1;

    // Reset state on every address, both ports.
    for (int a = 0; a < 16; a++) begin
      raddr_a = 4'(a); raddr_b = 4'(15 - a); #1;
      chk("rst_rd_a", 32'(rdata_a), 32'h0);
      chk("rst_rd_b", 32'(rdata_b), 32'h0);
    end
    chk("rst_changed", 32'(io_changed), 32'h0);
    chk_on = 1'b1;
    tick(1);

    // Write GPR3 while reading it on both ports: no bypass.
    we = 1'b1; waddr = 4'd3; wdata = 8'hA5; raddr_a = 4'd3; raddr_b = 4'd3; #1;
    chk("nobypass_a", 32'(rdata_a), 32'h00);
    chk("nobypass_b", 32'(rdata_b), 32'h00);
    tick(1); we = 1'b0; #1;
    chk("after_wr_a", 32'(rdata_a), 32'hA5);
    chk("after_wr_b", 32'(rdata_b), 32'hA5);
    wr(4'd13, 8'hFF);
    raddr_a = 4'd13; raddr_b = 4'd3; #1;
    chk("unmapped_rd", 32'(rdata_a), 32'h00);
    chk("unmapped_keep", 32'(rdata_b), 32'hA5);
    wr(4'd0, 8'h11);
    raddr_a = 4'd0; #1;
    chk("gpr0_writable", 32'(rdata_a), 32'h11);

    // Port 0 mixed direction: upper nibble driven, lower nibble from bench.
    wr(4'd10, 8'hF0);
    wr(4'd8, 8'h3C);
    tb_val[0] = 8'h09; raddr_a = 4'd8; #1;
    chk("p0_pad_hi", 32'(io[7:4]), 32'h3);
    chk("p0_lat0", 32'(rdata_a), 32'h30);
    tick(1); #1;
    chk("p0_lat1", 32'(rdata_a), 32'h30);
    tick(1); #1;
    chk("p0_lat2", 32'(rdata_a), 32'h39);

    // Port 1 input change: pulse SYNC_STAGES+1 edges later, one cycle wide.
    tb_val[1] = 8'h01;
    tick(2); #1;
    chk("p1_chg_e2", 32'(io_changed[1]), 32'h0);
    tick(1); #1;
    chk("p1_chg_e3", 32'(io_changed[1]), 32'h1);
    tick(1); #1;
    chk("p1_chg_e4", 32'(io_changed[1]), 32'h0);

    // OUT write on an input port: no pulse.
    wr(4'd9, 8'hFF);
    repeat (4) begin
      tick(1); #1;
      chk("p1_outwr_nochg", 32'(io_changed[1]), 32'h0);
    end

    // Output-direction bit toggling: no pulse.
    wr(4'd11, 8'h80);
    wr(4'd9, 8'h7F);
    repeat (4) begin
      tick(1); #1;
      chk("p1_dirbit_nochg", 32'(io_changed[1]), 32'h0);
    end

    // Output -> input: readback switches to the synchronised pad at once.
    wr(4'd11, 8'hFF);
    tick(3);
    tb_val[1] = 8'hF0;
    wr(4'd9, 8'hF0);
    wr(4'd11, 8'h00);
    raddr_a = 4'd9; #1;
    chk("p1_dirflip_rd0", 32'(rdata_a), 32'h7F);
    tick(1); #1;
    chk("p1_dirflip_rd1", 32'(rdata_a), 32'hF0);

    // Continuously toggling input: back-to-back pulses.
    for (int i = 0; i < 6; i++) begin
      if (i < 4) tb_val[1] ^= 8'h04;
      tick(1); #1;
      if (i == 2 || i == 3) chk("p1_toggle_pulse", 32'(io_changed[1]), 32'h1);
    end

    // Asynchronous reset between edges releases the pads immediately.
    wr(4'd10, 8'hFF);
    wr(4'd8, 8'h55);
    tb_val[0] = 8'hAA; raddr_a = 4'd8; raddr_b = 4'd10;
    tick(1); #1;
    chk("pre_rst_out0", 32'(rdata_a), 32'h55);
    chk("pre_rst_dir0", 32'(rdata_b), 32'hFF);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_out0", 32'(rdata_a), 32'h00);
    chk("async_rst_dir0", 32'(rdata_b), 32'h00);
    chk("async_rst_pad0", 32'(io[7:0]), 32'hAA);
    chk("async_rst_chg",  32'(io_changed), 32'h0);
    #10 rst_n = 1'b1;
    tick(2);

    // Wide instance: address map, 3-edge latency, change detect on port 2.
    wr1(5'd15, 16'hBEEF);
    ra1a = 5'd15; #1;
    chk("u1_gpr15", 32'(rd1a), 32'hBEEF);
    wr1(5'd22, 16'h1234);
    ra1a = 5'd22; ra1b = 5'd15; #1;
    chk("u1_unmapped_rd", 32'(rd1a), 32'h0);
    chk("u1_unmapped_keep", 32'(rd1b), 32'hBEEF);
    wr1(5'd21, 16'hFF00);
    en1[47:32] = 16'h00FF;
    wr1(5'd18, 16'hAB00);
    tick(5);
    ra1a = 5'd21; ra1b = 5'd16; #1;
    chk("u1_dir2", 32'(rd1a), 32'hFF00);
    chk("u1_out0_rd", 32'(rd1b), 32'h0);
    chk("u1_pad2_hi", 32'(io1[47:40]), 32'hAB);
    chk("u1_chg_quiet", 32'(ch1), 32'h0);
    val1[47:32] = 16'h00CD; ra1a = 5'd18;
    tick(2); #1;
    chk("u1_lat2", 32'(rd1a), 32'hAB00);
    tick(1); #1;
    chk("u1_lat3", 32'(rd1a), 32'hABCD);
    chk("u1_chg_e3", 32'(ch1[2]), 32'h0);
    tick(1); #1;
    chk("u1_chg_e4", 32'(ch1[2]), 32'h1);
    tick(1); #1;
    chk("u1_chg_e5", 32'(ch1[2]), 32'h0);

    tick(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
